// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Holds the forwarding select codes, the FSM state type and the default register-address width.
package pipe_pkg;

    localparam int DEF_REG_AW = 3;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forwarding-select comparator for one EX operand.
// The youngest producer wins, so a MEM-stage match has priority over a WB-stage match.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] src,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_wr_addr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_wr_addr,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_valid && mem_reg_write && (mem_wr_addr == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_wr_addr == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard and stall controller for the five-stage pipeline: load-use bubbles,
// branch flushes, multi-cycle execute holds, operand forwarding and a stall counter.
module hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic              id_rs_used,
    input  logic              id_rd_used,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_valid,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              ex_multicycle,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] ex_wr_addr,
    input  logic              br_taken,
    input  logic              mem_valid,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_wr_addr,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_wr_addr,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              bubble_ex,
    output logic              bubble_mem,
    output logic              flush_if_id,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [3:0]       MC_LOAD = 4'(MC_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hz_state_t  state, next_state;
    logic [3:0] mc_cnt, next_cnt;
    logic       load_use;

    assign load_use = ex_valid && ex_mem_read && ex_reg_write && id_valid &&
                      ((id_rs_used && (ex_wr_addr == id_rs)) ||
                       (id_rd_used && (ex_wr_addr == id_rd)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mc_cnt <= 4'd0;
        end else begin
            state  <= next_state;
            mc_cnt <= next_cnt;
        end
    end

    // Priority in IDLE: multi-cycle start, then branch, then load-use.
    // Stall controls are also gated by reset so they fall the moment reset asserts.
    always_comb begin
        next_state  = state;
        next_cnt    = mc_cnt;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        bubble_mem  = 1'b0;
        flush_if_id = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (ex_valid && ex_multicycle) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        next_cnt   = MC_LOAD;
                        next_state = MC_BUSY;
                    end else if (br_taken) begin
                        flush_if_id = 1'b1;
                        bubble_ex   = 1'b1;
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (mc_cnt != 4'd0) begin
                        stall_if   = 1'b1;
                        stall_id   = 1'b1;
                        stall_ex   = 1'b1;
                        bubble_mem = 1'b1;
                        next_cnt   = mc_cnt - 4'd1;
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign mc_busy = (state == MC_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_if && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src           (ex_rs),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_wr_addr   (mem_wr_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .sel           (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src           (ex_rd),
        .mem_valid     (mem_valid),
        .mem_reg_write (mem_reg_write),
        .mem_wr_addr   (mem_wr_addr),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_addr    (wb_wr_addr),
        .sel           (fwd_b)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: two instances (MC_LAT=4/CNT_W=16 and MC_LAT=16/CNT_W=4)
// share one stimulus stream and are compared against a cycle-age reference model.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rd_used;
    logic [2:0] id_rs, id_rd;
    logic       ex_valid, ex_mem_read, ex_reg_write, ex_multicycle;
    logic [2:0] ex_rs, ex_rd, ex_wr_addr;
    logic       br_taken;
    logic       mem_valid, mem_reg_write;
    logic [2:0] mem_wr_addr;
    logic       wb_reg_write;
    logic [2:0] wb_wr_addr;

    logic        sif0, sid0, sex0, bex0, bmem0, fl0, busy0;
    logic [1:0]  fa0, fb0;
    logic [15:0] cnt0;
    logic        sif1, sid1, sex1, bex1, bmem1, fl1, busy1;
    logic [1:0]  fa1, fb1;
    logic [3:0]  cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    int age[2];
    int cnt_model[2];
    int lat[2]  = '{4, 16};
    int cmax[2] = '{65535, 15};
    logic exp_stall[2];
    logic exp_start[2];

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(3), .MC_LAT(4), .CNT_W(16)) u_hz0 (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rd_used(id_rd_used),
        .id_rs(id_rs), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_multicycle(ex_multicycle), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_wr_addr(ex_wr_addr),
        .br_taken(br_taken), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_wr_addr(mem_wr_addr), .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr),
        .stall_if(sif0), .stall_id(sid0), .stall_ex(sex0), .bubble_ex(bex0),
        .bubble_mem(bmem0), .flush_if_id(fl0), .fwd_a(fa0), .fwd_b(fb0),
        .mc_busy(busy0), .stall_cnt(cnt0)
    );

    hazard_unit #(.REG_AW(3), .MC_LAT(16), .CNT_W(4)) u_hz1 (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs_used(id_rs_used), .id_rd_used(id_rd_used),
        .id_rs(id_rs), .id_rd(id_rd),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_multicycle(ex_multicycle), .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_wr_addr(ex_wr_addr),
        .br_taken(br_taken), .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
        .mem_wr_addr(mem_wr_addr), .wb_reg_write(wb_reg_write), .wb_wr_addr(wb_wr_addr),
        .stall_if(sif1), .stall_id(sid1), .stall_ex(sex1), .bubble_ex(bex1),
        .bubble_mem(bmem1), .flush_if_id(fl1), .fwd_a(fa1), .fwd_b(fb1),
        .mc_busy(busy1), .stall_cnt(cnt1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearInputs();
        id_valid = 0; id_rs_used = 0; id_rd_used = 0; id_rs = 0; id_rd = 0;
        ex_valid = 0; ex_mem_read = 0; ex_reg_write = 0; ex_multicycle = 0;
        ex_rs = 0; ex_rd = 0; ex_wr_addr = 0; br_taken = 0;
        mem_valid = 0; mem_reg_write = 0; mem_wr_addr = 0;
        wb_reg_write = 0; wb_wr_addr = 0;
    endtask

    function automatic logic [1:0] modelFwd(input logic [2:0] src);
        if (mem_valid && mem_reg_write && mem_wr_addr == src) return 2'b01;
        if (wb_reg_write && wb_wr_addr == src) return 2'b10;
        return 2'b00;
    endfunction

    // age = cycles since the multi-cycle op entered EX (-1 when none); stalls while age <= MC_LAT-2.
    task automatic checkInst(input int k, input logic sif, sid, sex, bex, bmem, fl, busy,
                             input logic [1:0] fa, fb, input int cnt);
        logic idle, start, mcs, hz, brk, lu;
        string p;
        p = $sformatf("i%0d ", k);
        if (!rst_n) begin
            age[k] = -1;
            cnt_model[k] = 0;
        end
        idle  = (age[k] < 0);
        start = rst_n && idle && ex_valid && ex_multicycle;
        mcs   = start || (rst_n && age[k] >= 1 && age[k] <= lat[k] - 2);
        hz    = ex_valid && ex_mem_read && ex_reg_write && id_valid &&
                ((id_rs_used && ex_wr_addr == id_rs) || (id_rd_used && ex_wr_addr == id_rd));
        brk   = rst_n && idle && !start && br_taken;
        lu    = rst_n && idle && !start && !br_taken && hz;
        checkOutput({p, "stall_if"},    32'(sif),  32'(mcs | lu));
        checkOutput({p, "stall_id"},    32'(sid),  32'(mcs | lu));
        checkOutput({p, "stall_ex"},    32'(sex),  32'(mcs));
        checkOutput({p, "bubble_ex"},   32'(bex),  32'(brk | lu));
        checkOutput({p, "bubble_mem"},  32'(bmem), 32'(mcs));
        checkOutput({p, "flush_if_id"}, 32'(fl),   32'(brk));
        checkOutput({p, "mc_busy"},     32'(busy), 32'(age[k] >= 1));
        checkOutput({p, "fwd_a"},       32'(fa),   32'(modelFwd(ex_rs)));
        checkOutput({p, "fwd_b"},       32'(fb),   32'(modelFwd(ex_rd)));
        checkOutput({p, "stall_cnt"},   32'(cnt),  32'(cnt_model[k]));
        exp_stall[k] = mcs | lu;
        exp_start[k] = start;
    endtask

    task automatic evalCycle();
        #1;
        checkInst(0, sif0, sid0, sex0, bex0, bmem0, fl0, busy0, fa0, fb0, int'(cnt0));
        checkInst(1, sif1, sid1, sex1, bex1, bmem1, fl1, busy1, fa1, fb1, int'(cnt1));
    endtask

    task automatic finishCycle();
        for (int k = 0; k < 2; k++) begin
            if (rst_n) begin
                if (exp_start[k]) age[k] = 1;
                else if (age[k] >= 1) begin
                    age[k]++;
                    if (age[k] >= lat[k]) age[k] = -1;
                end
                if (exp_stall[k] && cnt_model[k] < cmax[k]) cnt_model[k]++;
            end
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus();
        evalCycle();
        finishCycle();
    endtask

    initial begin
        int stalls;
        age = '{-1, -1};
        cnt_model = '{0, 0};
        clearInputs();
        rst_n = 0;
        @(negedge clk);
        applyStimulus();
        rst_n = 1;
        applyStimulus();

        // load-use on Rs
        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_wr_addr = 3;
        id_valid = 1; id_rs = 3; id_rs_used = 1;
        evalCycle();
        checkOutput("lu stall_if", 32'(sif0), 32'd1);
        finishCycle();
        clearInputs();
        evalCycle();
        checkOutput("lu release", 32'(sif0), 32'd0);
        checkOutput("lu stall_cnt", 32'(cnt0), 32'd1);
        finishCycle();

        // multi-cycle op held for four cycles
        stalls = 0;
        ex_valid = 1; ex_multicycle = 1;
        for (int i = 0; i < 4; i++) begin
            evalCycle();
            if (sif0) stalls++;
            finishCycle();
        end
        clearInputs();
        evalCycle();
        checkOutput("mc stall length", 32'(stalls), 32'd3);
        checkOutput("mc back to idle", 32'(busy0), 32'd0);
        checkOutput("mc stall_cnt", 32'(cnt0), 32'd4);
        finishCycle();

        // branch beats load-use
        ex_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_wr_addr = 6;
        id_valid = 1; id_rd = 6; id_rd_used = 1; br_taken = 1;
        evalCycle();
        checkOutput("br flush", 32'(fl0), 32'd1);
        checkOutput("br bubble_ex", 32'(bex0), 32'd1);
        checkOutput("br no stall", 32'(sif0), 32'd0);
        finishCycle();

        // forwarding priority
        clearInputs();
        ex_rs = 5; ex_rd = 2; mem_valid = 1; mem_reg_write = 1; mem_wr_addr = 5;
        wb_reg_write = 1; wb_wr_addr = 5;
        evalCycle();
        checkOutput("fwd mem prio", 32'(fa0), 32'd1);
        checkOutput("fwd b none", 32'(fb0), 32'd0);
        finishCycle();
        mem_reg_write = 0;
        evalCycle();
        checkOutput("fwd wb", 32'(fa0), 32'd2);
        finishCycle();

        // reset on the second MC_BUSY cycle
        clearInputs();
        ex_valid = 1; ex_multicycle = 1;
        applyStimulus();
        applyStimulus();
        rst_n = 0;
        evalCycle();
        checkOutput("rst stall drop", 32'(sif0), 32'd0);
        checkOutput("rst busy drop", 32'(busy0), 32'd0);
        checkOutput("rst cnt clear", 32'(cnt0), 32'd0);
        finishCycle();
        rst_n = 1;
        clearInputs();
        for (int i = 0; i < 3; i++) applyStimulus();

        // saturation on the 4-bit counter with two 16-cycle ops
        ex_valid = 1; ex_multicycle = 1;
        for (int i = 0; i < 32; i++) applyStimulus();
        clearInputs();
        evalCycle();
        checkOutput("sat stall_cnt", 32'(cnt1), 32'd15);
        finishCycle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 63) != 0);
            id_valid      = 1'($urandom);
            id_rs_used    = 1'($urandom);
            id_rd_used    = 1'($urandom);
            id_rs         = 3'($urandom);
            id_rd         = 3'($urandom);
            ex_valid      = 1'($urandom);
            ex_mem_read   = 1'($urandom);
            ex_reg_write  = 1'($urandom);
            ex_multicycle = ($urandom_range(0, 7) == 0);
            ex_rs         = 3'($urandom);
            ex_rd         = 3'($urandom);
            ex_wr_addr    = 3'($urandom);
            br_taken      = ($urandom_range(0, 3) == 0);
            mem_valid     = 1'($urandom);
            mem_reg_write = 1'($urandom);
            mem_wr_addr   = 3'($urandom);
            wb_reg_write  = 1'($urandom);
            wb_wr_addr    = 3'($urandom);
            applyStimulus();
        end

        rst_n = 1;
        clearInputs();
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
